// File: rtl/count_step_monitor.sv
// Step checker for a W-bit up/down counter: classifies each sampled transition,
// checks it against the commanded direction, and keeps wrap/error statistics.
module count_step_monitor #(
    parameter int W  = 3,
    parameter int CW = 8,
    parameter int EW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [W-1:0]  q_in,
    input  logic          m_in,
    input  logic          clr,
    output logic          step_up,
    output logic          step_dn,
    output logic          wrap_pulse,
    output logic [CW-1:0] wrap_count,
    output logic          err,
    output logic [EW-1:0] err_count,
    output logic [W-1:0]  last_q,
    output logic [1:0]    state
);

    typedef enum logic [1:0] {
        ST_INIT  = 2'b00,
        ST_TRACK = 2'b01,
        ST_FAULT = 2'b10
    } state_t;

    function automatic logic [CW-1:0] sat_inc_cw(input logic [CW-1:0] v);
        if (v == {CW{1'b1}}) sat_inc_cw = v;
        else                 sat_inc_cw = v + {{(CW-1){1'b0}}, 1'b1};
    endfunction

    function automatic logic [EW-1:0] sat_inc_ew(input logic [EW-1:0] v);
        if (v == {EW{1'b1}}) sat_inc_ew = v;
        else                 sat_inc_ew = v + {{(EW-1){1'b0}}, 1'b1};
    endfunction

    state_t        r_state;
    state_t        w_state_nxt;
    logic [W-1:0]  r_cur_q;
    logic [W-1:0]  r_prev_q;
    logic          r_m_prev;
    logic          r_grace;
    logic          r_init_cnt;
    logic          r_step_up;
    logic          r_step_dn;
    logic          r_wrap;
    logic [CW-1:0] r_wrap_cnt;
    logic          r_err;
    logic [EW-1:0] r_err_cnt;

    logic [W-1:0]  w_delta;
    logic          w_active;
    logic          w_is_up;
    logic          w_is_dn;
    logic          w_is_stall;
    logic          w_dir_err;
    logic          w_error;
    logic          w_up_ok;
    logic          w_dn_ok;
    logic          w_wrap;

    // Transition classification of the two most recent samples
    always_comb begin
        w_delta    = r_cur_q - r_prev_q;
        w_active   = (r_state != ST_INIT);
        w_is_stall = (w_delta == {W{1'b0}});
        w_is_up    = (w_delta == {{(W-1){1'b0}}, 1'b1});
        w_is_dn    = (w_delta == {W{1'b1}});
        // A direction mismatch is excused for the one sample after m changes
        w_dir_err  = !r_grace && ((w_is_up && r_m_prev) || (w_is_dn && !r_m_prev));
        w_error    = w_active && ((!w_is_stall && !w_is_up && !w_is_dn) || w_dir_err);
        w_up_ok    = w_active && w_is_up && !w_dir_err;
        w_dn_ok    = w_active && w_is_dn && !w_dir_err;
        w_wrap     = (w_up_ok && (r_cur_q == {W{1'b0}})) ||
                     (w_dn_ok && (r_cur_q == {W{1'b1}}));
    end

    // Next-state logic for the tracking FSM
    always_comb begin
        w_state_nxt = r_state;
        if (clr) begin
            w_state_nxt = ST_INIT;
        end else begin
            case (r_state)
                ST_INIT: begin
                    if (r_init_cnt) w_state_nxt = ST_TRACK;
                    else            w_state_nxt = ST_INIT;
                end
                ST_TRACK: begin
                    if (w_error) w_state_nxt = ST_FAULT;
                    else         w_state_nxt = ST_TRACK;
                end
                ST_FAULT: w_state_nxt = ST_FAULT;
                default:  w_state_nxt = ST_INIT;
            endcase
        end
    end

    // Sampling pipeline, FSM register and registered statistics
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= ST_INIT;
            r_cur_q    <= {W{1'b0}};
            r_prev_q   <= {W{1'b0}};
            r_m_prev   <= 1'b0;
            r_grace    <= 1'b0;
            r_init_cnt <= 1'b0;
            r_step_up  <= 1'b0;
            r_step_dn  <= 1'b0;
            r_wrap     <= 1'b0;
            r_wrap_cnt <= {CW{1'b0}};
            r_err      <= 1'b0;
            r_err_cnt  <= {EW{1'b0}};
        end else begin
            r_cur_q  <= q_in;
            r_prev_q <= r_cur_q;
            r_m_prev <= m_in;
            r_grace  <= (m_in != r_m_prev);
            r_state  <= w_state_nxt;
            if (clr || (r_state != ST_INIT)) r_init_cnt <= 1'b0;
            else                             r_init_cnt <= 1'b1;
            if (clr) begin
                r_step_up  <= 1'b0;
                r_step_dn  <= 1'b0;
                r_wrap     <= 1'b0;
                r_wrap_cnt <= {CW{1'b0}};
                r_err      <= 1'b0;
                r_err_cnt  <= {EW{1'b0}};
            end else begin
                r_step_up <= w_up_ok;
                r_step_dn <= w_dn_ok;
                r_wrap    <= w_wrap;
                if (w_wrap) r_wrap_cnt <= sat_inc_cw(r_wrap_cnt);
                if (w_error) begin
                    r_err     <= 1'b1;
                    r_err_cnt <= sat_inc_ew(r_err_cnt);
                end
            end
        end
    end

    assign step_up    = r_step_up;
    assign step_dn    = r_step_dn;
    assign wrap_pulse = r_wrap;
    assign wrap_count = r_wrap_cnt;
    assign err        = r_err;
    assign err_count  = r_err_cnt;
    assign last_q     = r_cur_q;
    assign state      = r_state;

endmodule

// File: tb/tb_count_step_monitor.sv
// Directed bench for count_step_monitor: inputs change on the falling edge,
// outputs are checked 1 time unit after each rising edge.
module tb_count_step_monitor;

    logic       clk;
    logic       rst;
    logic [2:0] q_in;
    logic       m_in;
    logic       clr;
    logic       step_up;
    logic       step_dn;
    logic       wrap_pulse;
    logic [7:0] wrap_count;
    logic       err;
    logic [7:0] err_count;
    logic [2:0] last_q;
    logic [1:0] state;

    int n_cmp = 0;
    int n_bad = 0;

    count_step_monitor #(.W(3), .CW(8), .EW(8)) dut (
        .clk(clk), .rst(rst), .q_in(q_in), .m_in(m_in), .clr(clr),
        .step_up(step_up), .step_dn(step_dn), .wrap_pulse(wrap_pulse),
        .wrap_count(wrap_count), .err(err), .err_count(err_count),
        .last_q(last_q), .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input logic [2:0] q, input logic m, input logic r, input logic c);
        @(negedge clk);
        q_in = q;
        m_in = m;
        rst  = r;
        clr  = c;
        @(posedge clk);
        #1;
    endtask

    logic [2:0] dn_seq [8];
    logic [2:0] g_q    [7];
    logic       g_m    [7];
    logic       g_up   [7];
    logic       g_dn   [7];
    logic [2:0] qv;

    initial begin
        rst = 1'b0; clr = 1'b0; q_in = 3'd0; m_in = 1'b0;
        dn_seq = '{3'd3, 3'd2, 3'd1, 3'd0, 3'd7, 3'd6, 3'd6, 3'd6};
        g_q    = '{3'd2, 3'd3, 3'd4, 3'd5, 3'd4, 3'd3, 3'd3};
        g_m    = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        g_up   = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        g_dn   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

        // reset state
        step(3'd0, 1'b0, 1'b0, 1'b0);
        step(3'd0, 1'b0, 1'b0, 1'b0);
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_wcnt", 32'(wrap_count), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_ecnt", 32'(err_count), 32'd0);
        chk("rst_up", 32'(step_up), 32'd0);

        // up count 0..7,0,1 with m=0
        for (int i = 0; i < 10; i++) begin
            step(3'(i), 1'b0, 1'b1, 1'b0);
            if (i == 0) chk("up_init0", 32'(state), 32'd0);
            if (i == 1) chk("up_track", 32'(state), 32'd1);
            if (i >= 2) begin
                chk("up_pulse", 32'(step_up), 32'd1);
                chk("up_wrap", 32'(wrap_pulse), 32'(i == 9));
            end
        end
        chk("up_wcnt", 32'(wrap_count), 32'd1);
        chk("up_err", 32'(err), 32'd0);
        chk("up_state", 32'(state), 32'd1);

        // clr coinciding with a 1->3 jump: clr wins
        step(3'd3, 1'b1, 1'b1, 1'b1);
        chk("clr_wcnt", 32'(wrap_count), 32'd0);
        chk("clr_err", 32'(err), 32'd0);
        chk("clr_state", 32'(state), 32'd0);
        chk("clr_lastq", 32'(last_q), 32'd3);

        // down count 3,2,1,0,7,6 with m=1
        for (int i = 0; i < 8; i++) begin
            step(dn_seq[i], 1'b1, 1'b1, 1'b0);
            chk("dn_pulse", 32'(step_dn), 32'((i >= 2) && (i <= 6)));
            chk("dn_wrap", 32'(wrap_pulse), 32'(i == 5));
        end
        chk("dn_wcnt", 32'(wrap_count), 32'd1);
        chk("dn_err", 32'(err), 32'd0);

        // direction switch with one spurious up step during grace
        step(3'd2, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 7; i++) begin
            step(g_q[i], g_m[i], 1'b1, 1'b0);
            chk("gr_up", 32'(step_up), 32'(g_up[i]));
            chk("gr_dn", 32'(step_dn), 32'(g_dn[i]));
            chk("gr_err", 32'(err), 32'd0);
        end

        // jump 2->5 forces FAULT
        step(3'd2, 1'b1, 1'b1, 1'b0);
        step(3'd5, 1'b1, 1'b1, 1'b0);
        chk("jp_pre_dn", 32'(step_dn), 32'd1);
        chk("jp_pre_state", 32'(state), 32'd1);
        step(3'd4, 1'b1, 1'b1, 1'b0);
        chk("jp_err", 32'(err), 32'd1);
        chk("jp_ecnt", 32'(err_count), 32'd1);
        chk("jp_state", 32'(state), 32'd2);
        chk("jp_nopulse", 32'(step_dn | step_up), 32'd0);
        step(3'd3, 1'b1, 1'b1, 1'b0);
        chk("flt_dn", 32'(step_dn), 32'd1);
        chk("flt_state", 32'(state), 32'd2);
        chk("flt_ecnt", 32'(err_count), 32'd1);
        step(3'd3, 1'b1, 1'b1, 1'b1);
        chk("fclr_err", 32'(err), 32'd0);
        chk("fclr_ecnt", 32'(err_count), 32'd0);
        chk("fclr_state", 32'(state), 32'd0);
        chk("fclr_dn", 32'(step_dn), 32'd0);

        // up steps against m=1: err_count saturation
        step(3'd3, 1'b1, 1'b1, 1'b0);
        step(3'd4, 1'b1, 1'b1, 1'b0);
        qv = 3'd4;
        for (int k = 0; k < 300; k++) begin
            qv = qv + 3'd1;
            step(qv, 1'b1, 1'b1, 1'b0);
            if (k == 0) begin
                chk("sat_first", 32'(err_count), 32'd1);
                chk("sat_state", 32'(state), 32'd2);
                chk("sat_noup", 32'(step_up), 32'd0);
            end
            if (k == 253) chk("sat_254", 32'(err_count), 32'd254);
        end
        chk("sat_255", 32'(err_count), 32'd255);
        chk("sat_wcnt", 32'(wrap_count), 32'd0);
        chk("sat_err", 32'(err), 32'd1);

        // reset while a 7->0 wrap is pending
        step(3'd5, 1'b0, 1'b0, 1'b0);
        step(3'd5, 1'b0, 1'b1, 1'b0);
        step(3'd6, 1'b0, 1'b1, 1'b0);
        step(3'd7, 1'b0, 1'b1, 1'b0);
        chk("mr_up1", 32'(step_up), 32'd1);
        step(3'd0, 1'b0, 1'b1, 1'b0);
        chk("mr_up2", 32'(step_up), 32'd1);
        chk("mr_nowrap", 32'(wrap_pulse), 32'd0);
        step(3'd1, 1'b0, 1'b0, 1'b0);
        chk("mr_wrap_drop", 32'(wrap_pulse), 32'd0);
        chk("mr_up0", 32'(step_up), 32'd0);
        chk("mr_state", 32'(state), 32'd0);
        chk("mr_lastq", 32'(last_q), 32'd0);
        chk("mr_wcnt", 32'(wrap_count), 32'd0);
        chk("mr_ecnt", 32'(err_count), 32'd0);
        chk("mr_err", 32'(err), 32'd0);
        step(3'd1, 1'b0, 1'b1, 1'b0);
        chk("mr_init1", 32'(state), 32'd0);
        step(3'd2, 1'b0, 1'b1, 1'b0);
        chk("mr_track", 32'(state), 32'd1);
        chk("mr_quiet", 32'(step_up), 32'd0);
        step(3'd3, 1'b0, 1'b1, 1'b0);
        chk("mr_first", 32'(step_up), 32'd1);
        chk("mr_first_wrap", 32'(wrap_pulse), 32'd0);
        chk("mr_first_err", 32'(err), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
